hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Control-side consumer of the ID/EX pipeline register outputs: Rn_EX, Rm_EX, fwdEn_EX, targetReg_EX, RegWrite_EX and memRead_EX.
- Keeps shadow EX→MEM→WB destination tracking and generates ALU operand forwarding selects.
- Detects load-use hazards and drives stall/bubble controls back into PC, IF/ID and ID/EX.
- Sequences the branch-taken flush.

Parameters:
ZERO_REG, 31, register index that is never forwarded or hazard-checked (XZR)
LOAD_STALL_CYCLES, 1, total cycles the front end is held per load-use hazard (>=1)
FLUSH_CYCLES, 2, total cycles IF/ID and ID/EX are squashed per taken branch (>=1)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset; 0 = reset
Rn_ID  in  5  source register 1 of instruction in ID
Rm_ID  in  5  source register 2 of instruction in ID
useRn_ID  in  1  ID instruction reads Rn
useRm_ID  in  1  ID instruction reads Rm
Rn_EX  in  5  source register 1 of instruction in EX
Rm_EX  in  5  source register 2 of instruction in EX
fwdEn_EX  in  2  bit0 enables forwarding for Rn, bit1 for Rm
targetReg_EX  in  5  destination register of EX instruction
RegWrite_EX  in  1  EX instruction writes register file
memRead_EX  in  1  EX instruction is a load
brTaken_EX  in  1  branch resolved taken in EX this cycle
fwdA  out  2  operand A select: 00 regfile, 01 MEM result, 10 WB result
fwdB  out  2  operand B select, same encoding
pcWrite  out  1  0 = hold PC
ifIdWrite  out  1  0 = hold IF/ID
idExBubble  out  1  1 = load zero control bits into ID/EX
flushIfId  out  1  1 = clear IF/ID to NOP
state  out  2  FSM state (debug): 00 RUN, 01 STALL, 10 FLUSH

Behaviour:
- Shadow pipeline: each posedge, the MEM stage takes {targetReg_EX, RegWrite_EX, memRead_EX} and the WB stage takes the MEM stage. It shifts every cycle regardless of stall, because a bubble arrives on the EX inputs as RegWrite=0.
- Reset (reset==0 at posedge): state=RUN, counter=0, shadow dst=0, RegWrite=0, memRead=0. While reset==0, outputs are forced to fwdA=fwdB=00, pcWrite=1, ifIdWrite=1, idExBubble=0, flushIfId=0, regardless of inputs. Reset mid-stall or mid-flush aborts the sequence immediately.
- Forwarding is combinational, zero latency, with MEM priority over WB:
  - fwdA=01 if fwdEn_EX[0] & MEM.RegWrite & MEM.dst==Rn_EX & Rn_EX!=ZERO_REG.
  - Otherwise fwdA=10 if the same condition holds for the WB stage.
  - Otherwise fwdA=00.
  - fwdB is identical, using fwdEn_EX[1] and Rm_EX.
- Hazard condition: hazard = memRead_EX & RegWrite_EX & targetReg_EX!=ZERO_REG & ((useRn_ID & Rn_ID==targetReg_EX) | (useRm_ID & Rm_ID==targetReg_EX)).
- Stall outputs are pcWrite=0, ifIdWrite=0, idExBubble=1, flushIfId=0.
- Flush outputs are pcWrite=1, ifIdWrite=1, idExBubble=1, flushIfId=1.
- FSM, with Mealy assertion in the detecting cycle:
  - RUN:
    - brTaken_EX → flush outputs this cycle. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
    - Else hazard → stall outputs this cycle. If LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-1.
    - Else outputs are idle (1,1,0,0) and the FSM stays in RUN.
  - STALL: stall outputs; cnt decrements each cycle; at cnt==1, return to RUN. brTaken_EX in STALL → flush outputs this cycle and transfer to FLUSH (or RUN) as from RUN.
  - FLUSH: flush outputs; cnt decrements; at cnt==1, return to RUN. A new brTaken_EX in FLUSH reloads cnt=FLUSH_CYCLES-1. hazard is ignored in FLUSH.
- Priority when events coincide: brTaken_EX > hazard. Forwarding stays active in every state.
- Encoding 11 is never produced on fwdA/fwdB or on state.

Test Plan:
- Reset: hold reset=0 for 2 cycles with RegWrite_EX=1, brTaken_EX=1 → outputs stay at reset values and state=00; release reset → the first shadow entry is captured on the next posedge.
- Forwarding: EX writes X5 and the next EX has Rn_EX=5, fwdEn_EX=01 → fwdA=01. One cycle later, with a non-writing instruction between, fwdA=10. With MEM and WB both writing X5 → fwdA=01. With targetReg=31 → fwdA=00.
- Load-use: memRead_EX=1, RegWrite_EX=1, targetReg_EX=7, Rm_ID=7, useRm_ID=1 → pcWrite=0, ifIdWrite=0, idExBubble=1 for exactly 1 cycle. Two cycles later, with Rm_EX=7 and fwdEn_EX=10 → fwdB=10.
- Load-use with useRm_ID=0, or targetReg_EX=31 → no stall.
- Branch: brTaken_EX pulse for 1 cycle → flushIfId=1 and idExBubble=1 for 2 cycles (state 10 in the second), then RUN. brTaken_EX coincident with hazard → flush outputs only.
- LOAD_STALL_CYCLES=3: a hazard stalls 3 cycles; brTaken_EX in the 2nd stall cycle → flush outputs take over for FLUSH_CYCLES cycles.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding selects, load-use stall and branch-flush sequencing
// driven from the ID/EX register outputs and a shadow MEM/WB destination pipe.
module hazard_fwd_unit #(
    parameter int ZERO_REG          = 31,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rn_ID,
    input  logic [4:0] Rm_ID,
    input  logic       useRn_ID,
    input  logic       useRm_ID,
    input  logic [4:0] Rn_EX,
    input  logic [4:0] Rm_EX,
    input  logic [1:0] fwdEn_EX,
    input  logic [4:0] targetReg_EX,
    input  logic       RegWrite_EX,
    input  logic       memRead_EX,
    input  logic       brTaken_EX,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       idExBubble,
    output logic       flushIfId,
    output logic [1:0] state
);

    // state | meaning
    // RUN   | idle; hazard or taken branch handled combinationally this cycle
    // STALL | holding PC and IF/ID for the remaining load-use cycles
    // FLUSH | squashing IF/ID and ID/EX for the remaining branch cycles
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [4:0]       ZR         = 5'(ZERO_REG);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       mem_dst, wb_dst;
    logic             mem_rw, wb_rw;
    logic             hazard;
    logic             do_flush, do_stall;

    assign hazard = memRead_EX & RegWrite_EX & (targetReg_EX != ZR) &
                    ((useRn_ID & (Rn_ID == targetReg_EX)) |
                     (useRm_ID & (Rm_ID == targetReg_EX)));

    function automatic logic [1:0] fwd_sel(input logic en, input logic [4:0] src,
                                           input logic m_rw, input logic [4:0] m_dst,
                                           input logic w_rw, input logic [4:0] w_dst);
        if (en && src != ZR && m_rw && m_dst == src)
            return 2'b01;
        else if (en && src != ZR && w_rw && w_dst == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            st      <= RUN;
            cnt     <= '0;
            mem_dst <= '0;
            mem_rw  <= 1'b0;
            wb_dst  <= '0;
            wb_rw   <= 1'b0;
        end else begin
            // The shadow pipe never stalls: a bubble enters EX as RegWrite=0.
            mem_dst <= targetReg_EX;
            mem_rw  <= RegWrite_EX;
            wb_dst  <= mem_dst;
            wb_rw   <= mem_rw;
            if (brTaken_EX) begin
                if (FLUSH_CYCLES > 1) begin
                    st  <= FLUSH;
                    cnt <= FLUSH_LOAD;
                end else begin
                    st  <= RUN;
                    cnt <= '0;
                end
            end else begin
                case (st)
                    RUN: begin
                        if (hazard && LOAD_STALL_CYCLES > 1) begin
                            st  <= STALL;
                            cnt <= STALL_LOAD;
                        end
                    end
                    STALL, FLUSH: begin
                        if (cnt <= CNT_ONE) begin
                            st  <= RUN;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        st  <= RUN;
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Flush dominates; a hazard only matters outside FLUSH.
    assign do_flush = brTaken_EX | (st == FLUSH);
    assign do_stall = ~do_flush & ((st == STALL) | hazard);

    always_comb begin
        fwdA       = 2'b00;
        fwdB       = 2'b00;
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExBubble = 1'b0;
        flushIfId  = 1'b0;
        state      = RUN;
        if (reset) begin
            fwdA  = fwd_sel(fwdEn_EX[0], Rn_EX, mem_rw, mem_dst, wb_rw, wb_dst);
            fwdB  = fwd_sel(fwdEn_EX[1], Rm_EX, mem_rw, mem_dst, wb_rw, wb_dst);
            state = st;
            if (do_flush) begin
                idExBubble = 1'b1;
                flushIfId  = 1'b1;
            end else if (do_stall) begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExBubble = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: two instances (default and long stall/flush) against a
// register-history / remaining-cycle reference model.
module tb_hazard_fwd_unit;

    localparam int L0 = 1, F0 = 2;
    localparam int L1 = 3, F1 = 3;

    logic       clk;
    logic       reset;
    logic [4:0] Rn_ID, Rm_ID, Rn_EX, Rm_EX, targetReg_EX;
    logic       useRn_ID, useRm_ID, RegWrite_EX, memRead_EX, brTaken_EX;
    logic [1:0] fwdEn_EX;

    logic [1:0] fwdA0, fwdB0, state0, fwdA1, fwdB1, state1;
    logic       pcw0, ifw0, bub0, fl0, pcw1, ifw1, bub1, fl1;

    hazard_fwd_unit #(.ZERO_REG(31), .LOAD_STALL_CYCLES(L0), .FLUSH_CYCLES(F0)) u_dut0 (
        .clk(clk), .reset(reset), .Rn_ID(Rn_ID), .Rm_ID(Rm_ID),
        .useRn_ID(useRn_ID), .useRm_ID(useRm_ID), .Rn_EX(Rn_EX), .Rm_EX(Rm_EX),
        .fwdEn_EX(fwdEn_EX), .targetReg_EX(targetReg_EX), .RegWrite_EX(RegWrite_EX),
        .memRead_EX(memRead_EX), .brTaken_EX(brTaken_EX),
        .fwdA(fwdA0), .fwdB(fwdB0), .pcWrite(pcw0), .ifIdWrite(ifw0),
        .idExBubble(bub0), .flushIfId(fl0), .state(state0));

    hazard_fwd_unit #(.ZERO_REG(31), .LOAD_STALL_CYCLES(L1), .FLUSH_CYCLES(F1)) u_dut1 (
        .clk(clk), .reset(reset), .Rn_ID(Rn_ID), .Rm_ID(Rm_ID),
        .useRn_ID(useRn_ID), .useRm_ID(useRm_ID), .Rn_EX(Rn_EX), .Rm_EX(Rm_EX),
        .fwdEn_EX(fwdEn_EX), .targetReg_EX(targetReg_EX), .RegWrite_EX(RegWrite_EX),
        .memRead_EX(memRead_EX), .brTaken_EX(brTaken_EX),
        .fwdA(fwdA1), .fwdB(fwdB1), .pcWrite(pcw1), .ifIdWrite(ifw1),
        .idExBubble(bub1), .flushIfId(fl1), .state(state1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {fwdA,fwdB} and {pcWrite,ifIdWrite,idExBubble,flushIfId,state} per instance
    logic [7:0]  q_fwd[$];
    logic [11:0] q_ctl[$];

    // Reference model: last two EX writes plus remaining hold cycles.
    logic [4:0] hist_dst[2];
    logic       hist_rw[2];
    int         flush_left[2];
    int         stall_left[2];
    int         lcyc[2] = '{L0, L1};
    int         fcyc[2] = '{F0, F1};

    function automatic logic [1:0] exp_fwd(input logic en, input logic [4:0] src);
        if (!en || src == 5'd31) return 2'b00;
        if (hist_rw[0] && hist_dst[0] == src) return 2'b01;
        if (hist_rw[1] && hist_dst[1] == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rn_id, input logic [4:0] rm_id,
                         input logic urn, input logic urm, input logic [4:0] rn_ex,
                         input logic [4:0] rm_ex, input logic [1:0] fen, input logic [4:0] tgt,
                         input logic rw, input logic mr, input logic br);
        logic [1:0] fa, fb, st;
        logic [5:0] c[2];
        logic       haz;
        @(posedge clk);
        #1;
        reset = r; Rn_ID = rn_id; Rm_ID = rm_id; useRn_ID = urn; useRm_ID = urm;
        Rn_EX = rn_ex; Rm_EX = rm_ex; fwdEn_EX = fen; targetReg_EX = tgt;
        RegWrite_EX = rw; memRead_EX = mr; brTaken_EX = br;

        haz = mr && rw && tgt != 5'd31 &&
              ((urn && rn_id == tgt) || (urm && rm_id == tgt));
        if (!r) begin
            fa = 2'b00; fb = 2'b00;
            for (int k = 0; k < 2; k++) begin
                c[k] = 6'b110000;
                flush_left[k] = 0; stall_left[k] = 0;
            end
            hist_dst[0] = '0; hist_rw[0] = 1'b0;
            hist_dst[1] = '0; hist_rw[1] = 1'b0;
        end else begin
            fa = exp_fwd(fen[0], rn_ex);
            fb = exp_fwd(fen[1], rm_ex);
            for (int k = 0; k < 2; k++) begin
                st = (flush_left[k] > 0) ? 2'b10 : (stall_left[k] > 0) ? 2'b01 : 2'b00;
                if (br) begin
                    c[k] = {4'b1111, st};
                    flush_left[k] = fcyc[k] - 1; stall_left[k] = 0;
                end else if (flush_left[k] > 0) begin
                    c[k] = {4'b1111, st};
                    flush_left[k]--;
                end else if (stall_left[k] > 0) begin
                    c[k] = {4'b0010, st};
                    stall_left[k]--;
                end else if (haz) begin
                    c[k] = {4'b0010, st};
                    stall_left[k] = lcyc[k] - 1;
                end else begin
                    c[k] = {4'b1100, st};
                end
            end
            hist_dst[1] = hist_dst[0]; hist_rw[1] = hist_rw[0];
            hist_dst[0] = tgt;         hist_rw[0] = rw;
        end
        q_fwd.push_back({fa, fb, fa, fb});
        q_ctl.push_back({c[0], c[1]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        logic [7:0]  ef, af;
        logic [11:0] ec, ac;
        if (q_fwd.size() > 0 && q_ctl.size() > 0) begin
            ef = q_fwd.pop_front();
            ec = q_ctl.pop_front();
            af = {fwdA0, fwdB0, fwdA1, fwdB1};
            ac = {pcw0, ifw0, bub0, fl0, state0, pcw1, ifw1, bub1, fl1, state1};
            checks++;
            if (af !== ef) begin
                errors++;
                $display("FAIL fwd t=%0t got %b expected %b", $time, af, ef);
            end
            checks++;
            if (ac !== ec) begin
                errors++;
                $display("FAIL ctl t=%0t got %b expected %b", $time, ac, ec);
            end
        end
    end

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd5;
            1: return 5'd7;
            2: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        int wait_cnt;
        reset = 0; Rn_ID = 0; Rm_ID = 0; useRn_ID = 0; useRm_ID = 0; Rn_EX = 0; Rm_EX = 0;
        fwdEn_EX = 0; targetReg_EX = 0; RegWrite_EX = 0; memRead_EX = 0; brTaken_EX = 0;
        for (int k = 0; k < 2; k++) begin
            hist_dst[k] = '0; hist_rw[k] = 1'b0; flush_left[k] = 0; stall_left[k] = 0;
        end

        // reset held with active-looking inputs
        drive(0, 7, 7, 1, 1, 5, 5, 2'b11, 5, 1, 1, 1);
        drive(0, 7, 7, 1, 1, 5, 5, 2'b11, 5, 1, 1, 1);
        // forwarding: MEM, then WB through a non-writer
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 5, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 5, 0, 2'b01, 9, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0);
        // MEM and WB both write X5: MEM wins
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 5, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 5, 0, 2'b01, 5, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 5, 5, 2'b11, 0, 0, 0, 0);
        // zero register never forwarded
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 31, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 31, 31, 2'b11, 0, 0, 0, 0);
        idle(2);
        // load-use on Rm, then bubble, then forwarded from WB
        drive(1, 0, 7, 0, 1, 0, 0, 2'b00, 7, 1, 1, 0);
        drive(1, 0, 7, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 7, 2'b10, 0, 0, 0, 0);
        idle(3);
        // no stall: Rm unused, or load to X31
        drive(1, 0, 7, 0, 0, 0, 0, 2'b00, 7, 1, 1, 0);
        drive(1, 31, 31, 1, 1, 0, 0, 2'b00, 31, 1, 1, 0);
        idle(2);
        // branch pulse
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        idle(4);
        // branch coincident with hazard
        drive(1, 3, 0, 1, 0, 0, 0, 2'b00, 3, 1, 1, 1);
        idle(4);
        // hazard, then branch in the second stall cycle
        drive(1, 3, 0, 1, 0, 0, 0, 2'b00, 3, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        idle(5);
        // branch re-taken while flushing, then reset mid-stall
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        idle(4);
        drive(1, 4, 0, 1, 0, 0, 0, 2'b00, 4, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 60) != 0), pick_reg(), pick_reg(),
                  1'($urandom), 1'($urandom), pick_reg(), pick_reg(), 2'($urandom),
                  pick_reg(), 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0));
        end

        wait_cnt = 0;
        while (q_fwd.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        checks++;
        if (q_fwd.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q_fwd.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
